// File: rtl/mem_pkg.sv
// Shared encodings for the memory read controller: access sizes, FSM states,
// the default handshake timeout and the alignment rule.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    // A request is legal when its size is defined and the address is naturally aligned to it.
    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_read_ctrl_if.sv
// RAM-side four-phase handshake bundle: the controller is the master, the RAM the slave.
interface mem_read_ctrl_if #(
    parameter int ADDR_W = 32
) ();

    logic              MOV;
    logic [ADDR_W-1:0] MAddr;
    logic              MOC;
    logic [31:0]       MData;

    modport master (output MOV, output MAddr, input MOC, input MData);
    modport slave  (input MOV, input MAddr, output MOC, output MData);

endinterface

// File: rtl/mem_read_ctrl_load_extend.sv
// Little-endian lane select of a byte/halfword/word from a RAM word, followed by
// sign or zero extension to 32 bits.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] MData,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        signed_en,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = MData[7:0];
        case (addr_lo)
            2'd1:    w_byte = MData[15:8];
            2'd2:    w_byte = MData[23:16];
            2'd3:    w_byte = MData[31:24];
            default: w_byte = MData[7:0];
        endcase
        w_half = addr_lo[1] ? MData[31:16] : MData[15:0];
        case (size)
            SZ_BYTE: result = {{24{signed_en & w_byte[7]}}, w_byte};
            SZ_HALF: result = {{16{signed_en & w_half[15]}}, w_half};
            default: result = MData;
        endcase
    end

endmodule

// File: rtl/mem_read_ctrl.sv
// Load-side memory controller: issues a word-aligned read over a MOV/MOC
// four-phase handshake and returns the selected, extended lane in Q.
module mem_read_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [1:0]        Size,
    input  logic              Signed,
    mem_read_ctrl_if.master   mem,
    output logic [DATA_W-1:0] Q,
    output logic              Done,
    output logic              Err,
    output logic              Busy
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    logic [7:0]        r_cnt;
    logic [1:0]        r_addrLo;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_maddr;
    logic [DATA_W-1:0] r_q;
    logic              r_done;
    logic              r_err;

    state_t            w_stateNext;
    logic [7:0]        w_cntNext;
    logic              w_doneNext;
    logic              w_errNext;
    logic              w_latch;
    logic              w_loadQ;
    logic [31:0]       w_ext;

    load_extend u_extend (
        .MData     (mem.MData),
        .addr_lo   (r_addrLo),
        .size      (r_size),
        .signed_en (r_signed),
        .result    (w_ext)
    );

    // Completion on MOC takes priority over the timeout abort on the same edge.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_doneNext  = 1'b0;
        w_errNext   = 1'b0;
        w_latch     = 1'b0;
        w_loadQ     = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    if (is_legal(Size, Addr[1:0])) begin
                        w_latch     = 1'b1;
                        w_cntNext   = 8'd0;
                        w_stateNext = REQ;
                    end else begin
                        w_doneNext = 1'b1;
                        w_errNext  = 1'b1;
                    end
                end
            end
            REQ: begin
                if (mem.MOC) begin
                    w_loadQ     = 1'b1;
                    w_doneNext  = 1'b1;
                    w_stateNext = DROP;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_doneNext  = 1'b1;
                    w_errNext   = 1'b1;
                    w_cntNext   = 8'd0;
                    w_stateNext = DROP;
                end else begin
                    w_cntNext = r_cnt + 8'd1;
                end
            end
            DROP: begin
                if (!mem.MOC) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            r_state  <= IDLE;
            r_cnt    <= 8'd0;
            r_addrLo <= 2'b00;
            r_size   <= SZ_BYTE;
            r_signed <= 1'b0;
            r_maddr  <= '0;
            r_q      <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
            r_done  <= w_doneNext;
            r_err   <= w_errNext;
            if (w_latch) begin
                r_addrLo <= Addr[1:0];
                r_size   <= Size;
                r_signed <= Signed;
                r_maddr  <= {Addr[ADDR_W-1:2], 2'b00};
            end
            if (w_loadQ) begin
                r_q <= w_ext;
            end
        end
    end

    // MOV follows the state directly so an asynchronous reset drops it at once.
    assign mem.MOV   = (r_state == REQ);
    assign mem.MAddr = r_maddr;
    assign Q         = r_q;
    assign Done      = r_done;
    assign Err       = r_err;
    assign Busy      = (r_state != IDLE);

endmodule

// File: doc/mem_read_ctrl.md
# mem_read_ctrl

Memory read controller: the load-side counterpart of the 32-bit load-enabled register. On a one-cycle request it drives a word-aligned address and MOV to the RAM, waits for MOC, extracts the addressed byte, halfword or word from the returned word, and sign- or zero-extends it into a 32-bit data register (Q). It sits between the CPU datapath (load instructions feeding the register file) and the RAM model. It detects misalignment, reserved sizes and handshake timeouts.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; fixed at 32 for lane selection
- TIMEOUT, 15, cycles MOV may stay high without MOC before abort; range 1..255

- Clk  in  1  clock; all state updates on the rising edge
- Clr  in  1  reset, asynchronous, active-low
- Start  in  1  one-cycle read request; sampled only in IDLE
- Addr  in  ADDR_W  byte address of the load
- Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- Signed  in  1  1 = sign-extend, 0 = zero-extend (ignored for word)
- MOV  out  1  memory operation valid, to RAM
- MAddr  out  ADDR_W  {Addr[ADDR_W-1:2], 2'b00}, held stable while MOV=1
- MOC  in  1  memory operation complete, from RAM
- MData  in  32  RAM read data, valid while MOC=1
- Q  out  32  loaded, extended value
- Done  out  1  one-cycle completion pulse
- Err  out  1  one-cycle pulse coincident with Done on a failed request
- Busy  out  1  high in REQ and DROP

## Operation
- Reset (Clr=0, asynchronous) forces the following: state IDLE, MOV=0, MAddr=0, Q=0, Done=0, Err=0, Busy=0, timeout counter=0.
- States and transitions:
  - IDLE, with Start=1 and a legal request: latch Addr[1:0], Size and Signed; drive MAddr; go to REQ with MOV=1.
  - IDLE, with Start=1 and an illegal request: go to IDLE, pulse Done=1 and Err=1, leave Q unchanged, and do not assert MOV. A request is illegal if Size=11, if Size=01 with Addr[0]=1, or if Size=10 with Addr[1:0]≠0.
  - REQ, with MOC=1: load Q with the extended data; MOV→0; Done=1; go to DROP.
  - REQ, with MOC=0: increment the counter. When the counter reaches TIMEOUT: MOV→0; Done=1; Err=1; Q unchanged; go to DROP.
  - DROP: wait for MOC=0, then go to IDLE. This is the four-phase return-to-zero.
- Lane select is little-endian:
  - byte k = MData[8k+7:8k], where k = latched Addr[1:0];
  - halfword h = MData[16h+15:16h], where h = Addr[1];
  - word = MData.
- Extension: when Signed=1, replicate the MSB of the selected lane into the upper bits; when Signed=0, fill the upper bits with zeros.
- A Start received while Busy=1 is ignored and is not queued.
- Q holds its value between loads. It changes only on a successful completion or on reset.

## Timing
- Start is sampled at edge N. MOV and MAddr are valid after edge N, and Busy=1 from the same edge.
- MOC is sampled high at edge M. After edge M: Q is updated, Done=1 for exactly one cycle, and MOV=0.
- Minimum latency from Start to Done is 2 edges, when MOC is already high at the first REQ edge.
- Timeout: if MOC stays low for TIMEOUT consecutive REQ edges, the abort takes effect after the TIMEOUT-th REQ edge.
- MOC rising on the same edge that the counter reaches TIMEOUT: the completion wins and no Err is raised.
- A Start in the cycle immediately after DROP→IDLE is accepted. Back-to-back loads therefore take 3 cycles minimum.
- An illegal request produces Done and Err one cycle after Start, with no MOV activity.
- Reset mid-transaction drops MOV asynchronously. No Done is issued.

## Structure
- Package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD;
  - the state type {IDLE, REQ, DROP};
  - the default TIMEOUT.
- Sub-module load_extend: combinational lane select and sign/zero extension. Inputs are (MData, addr_lo[1:0], size, signed_en); output is 32 bits. The bench reuses it as a reference model.

## Test plan
- Word load: Addr=0x100, Size=10, RAM returns 0xDEADBEEF with MOC 3 cycles later → MAddr=0x100, Q=0xDEADBEEF, one-cycle Done, Err=0.
- Signed byte: Addr=0x103, Size=00, Signed=1, MData=0x80123456 → Q=0xFFFFFF80. Same access with Signed=0 → Q=0x00000080.
- Halfword: Addr=0x202, Size=01, Signed=1, MData=0x9ABC0000 → Q=0xFFFF9ABC. Addr=0x201 with Size=01 → Err and Done one cycle later, MOV never asserted, Q unchanged.
- Timeout: TIMEOUT=15 and MOC held low → MOV drops after 15 REQ edges, Done=Err=1, Q unchanged. The next load is not accepted until MOC has been low in DROP.
- Start while busy: a second Start during REQ is ignored, and only one Done is issued.
- Reset mid-REQ: Clr=0 while MOV=1 → MOV=0 and Q=0 immediately, no Done. After release, a fresh word load completes normally.
